// File: rtl/pb_io_pkg.sv
// Shared command codes, status bit positions and FSM encoding for the
// PicoBlaze RTC port bank.
package pb_io_pkg;

  localparam logic [7:0] CMD_COMMIT = 8'h09;
  localparam logic [7:0] CMD_SNAP   = 8'h0A;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_SNAPV = 3;
  localparam int ST_ACK   = 4;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } pb_state_e;

  function automatic bit ranges_overlap(int a_lo, int a_hi, int b_lo, int b_hi);
    return !((a_hi < b_lo) || (b_hi < a_lo));
  endfunction

  // True when the four port ranges are pairwise disjoint and addressable.
  function automatic bit port_map_ok(int ctrl, int wr_base, int num_wr, int stat,
                                     int rd_base, int num_rd, int addr_w);
    int wr_hi;
    int rd_hi;
    int limit;
    bit ok;
    wr_hi = wr_base + num_wr - 1;
    rd_hi = rd_base + num_rd - 1;
    limit = 1 << addr_w;
    ok = (num_wr > 0) && (num_rd > 0);
    if (ctrl >= limit || wr_hi >= limit || stat >= limit || rd_hi >= limit) ok = 1'b0;
    if (ranges_overlap(ctrl, ctrl, wr_base, wr_hi))    ok = 1'b0;
    if (ranges_overlap(ctrl, ctrl, stat, stat))        ok = 1'b0;
    if (ranges_overlap(ctrl, ctrl, rd_base, rd_hi))    ok = 1'b0;
    if (ranges_overlap(wr_base, wr_hi, stat, stat))    ok = 1'b0;
    if (ranges_overlap(wr_base, wr_hi, rd_base, rd_hi)) ok = 1'b0;
    if (ranges_overlap(stat, stat, rd_base, rd_hi))    ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/pb_shadow_reg.sv
// One double-buffered write register: CPU loads the shadow, commit copies it
// to the live output.
module pb_shadow_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              commit,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] live
);

  // live takes the pre-edge shadow, so a same-cycle load is not committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      if (load)   shadow <= din;
      if (commit) live   <= shadow;
    end
  end

endmodule

// File: rtl/pb_rtc_port_bank.sv
// PicoBlaze I/O register bank in front of the RTC: double-buffered write
// registers with a commit handshake, snapshot read-back and sticky status.
//
//   state      | meaning
//   S_IDLE     | no commit outstanding; COMMIT copies shadows to live outputs
//   S_WAIT_ACK | wr_req_o high, waiting for wr_ack_i; further COMMITs flag err
module pb_rtc_port_bank
  import pb_io_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter int              NUM_WR    = 9,
  parameter int              NUM_RD    = 9,
  parameter logic [ADDR_W-1:0] CTRL_PORT = 'h01,
  parameter logic [ADDR_W-1:0] WR_BASE   = 'h02,
  parameter logic [ADDR_W-1:0] STAT_PORT = 'h0C,
  parameter logic [ADDR_W-1:0] RD_BASE   = 'h0D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        port_id,
  input  logic [DATA_W-1:0]        out_port,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  output logic [DATA_W-1:0]        in_port,
  input  logic [NUM_RD*DATA_W-1:0] rd_vals_i,
  output logic [NUM_WR*DATA_W-1:0] wr_regs_o,
  output logic                     wr_req_o,
  input  logic                     wr_ack_i
);

  localparam bit MAP_OK = port_map_ok(int'(CTRL_PORT), int'(WR_BASE), NUM_WR,
                                      int'(STAT_PORT), int'(RD_BASE), NUM_RD, ADDR_W);

  generate
    if (!MAP_OK) begin : g_map_err
      $error("pb_rtc_port_bank: port ranges overlap or exceed ADDR_W");
    end
  endgenerate

  pb_state_e state_q, state_d;

  logic [DATA_W-1:0]        shadow_q [NUM_WR];
  logic [NUM_WR-1:0]        shadow_ld;
  logic [NUM_RD*DATA_W-1:0] snap_q;
  logic                     done_q, err_q, snapv_q;
  logic                     ctrl_wr, cmd_commit, cmd_snap, stat_rd;
  logic                     busy, commit_go, ack_done, err_set;
  logic [7:0]               stat_byte;
  logic [DATA_W-1:0]        rd_mux;

  assign ctrl_wr    = write_strobe && (port_id == CTRL_PORT);
  assign cmd_commit = ctrl_wr && (out_port == DATA_W'(CMD_COMMIT));
  assign cmd_snap   = ctrl_wr && (out_port == DATA_W'(CMD_SNAP));
  assign stat_rd    = read_strobe && (port_id == STAT_PORT);

  always_comb begin
    shadow_ld = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      shadow_ld[i] = write_strobe && (port_id == ADDR_W'(int'(WR_BASE) + i));
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
      pb_shadow_reg #(.DATA_W(DATA_W)) u_shadow (
        .clk    (clk),
        .reset  (reset),
        .load   (shadow_ld[gi]),
        .commit (commit_go),
        .din    (out_port),
        .shadow (shadow_q[gi]),
        .live   (wr_regs_o[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_commit) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (wr_ack_i)   state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_WAIT_ACK);
    commit_go = (state_q == S_IDLE) && cmd_commit;
    ack_done  = (state_q == S_WAIT_ACK) && wr_ack_i;
    err_set   = (state_q == S_WAIT_ACK) && cmd_commit;
  end

  // Sticky flags: clear-on-read first, set events override it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_req_o <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      snapv_q  <= 1'b0;
      snap_q   <= '0;
    end else begin
      if (commit_go)     wr_req_o <= 1'b1;
      else if (ack_done) wr_req_o <= 1'b0;

      if (ack_done)                 done_q <= 1'b1;
      else if (commit_go || stat_rd) done_q <= 1'b0;

      if (err_set)      err_q <= 1'b1;
      else if (stat_rd) err_q <= 1'b0;

      if (cmd_snap) begin
        snap_q  <= rd_vals_i;
        snapv_q <= 1'b1;
      end else if (stat_rd) begin
        snapv_q <= 1'b0;
      end
    end
  end

  always_comb begin
    stat_byte           = '0;
    stat_byte[ST_BUSY]  = busy;
    stat_byte[ST_DONE]  = done_q;
    stat_byte[ST_ERR]   = err_q;
    stat_byte[ST_SNAPV] = snapv_q;
    stat_byte[ST_ACK]   = wr_ack_i;
  end

  always_comb begin
    rd_mux = '0;
    if (port_id == STAT_PORT) rd_mux = DATA_W'(stat_byte);
    for (int j = 0; j < NUM_RD; j++) begin
      if (port_id == ADDR_W'(int'(RD_BASE) + j)) rd_mux = snap_q[j*DATA_W +: DATA_W];
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (port_id == ADDR_W'(int'(WR_BASE) + i)) rd_mux = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) in_port <= '0;
    else       in_port <= rd_mux;
  end

endmodule

// File: tb/tb_pb_rtc_port_bank.sv
// Directed plus randomized check of pb_rtc_port_bank against a cycle model
// built from arrays and flags.
module tb_pb_rtc_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  in_port;
  logic [71:0] rd_vals_i;
  logic [71:0] wr_regs_o;
  logic        wr_req_o;
  logic        wr_ack_i;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_shadow [9];
  logic [7:0] m_live   [9];
  logic [7:0] m_snap   [9];
  bit         m_busy, m_req, m_done, m_err, m_snapv;
  logic [7:0] m_in;

  always #5 clk = ~clk;

  pb_rtc_port_bank dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .rd_vals_i    (rd_vals_i),
    .wr_regs_o    (wr_regs_o),
    .wr_req_o     (wr_req_o),
    .wr_ack_i     (wr_ack_i)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next-cycle behaviour computed from the current inputs and model state.
  task automatic model_step();
    logic [7:0] rd;
    int p;
    bit commit, snap, stat_rd, go, fin, eset;
    logic [7:0] old_shadow [9];
    if (reset) begin
      for (int k = 0; k < 9; k++) begin
        m_shadow[k] = 8'h00; m_live[k] = 8'h00; m_snap[k] = 8'h00;
      end
      m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_snapv = 0;
      m_in = 8'h00;
      return;
    end
    p  = int'(port_id);
    rd = 8'h00;
    if (p == 12)                  rd = {3'b000, wr_ack_i, m_snapv, m_err, m_done, m_busy};
    else if (p >= 13 && p <= 21)  rd = m_snap[p-13];
    else if (p >= 2 && p <= 10)   rd = m_shadow[p-2];
    m_in = rd;

    commit  = write_strobe && p == 1 && out_port == 8'h09;
    snap    = write_strobe && p == 1 && out_port == 8'h0A;
    stat_rd = read_strobe && p == 12;
    go      = commit && !m_busy;
    eset    = commit && m_busy;
    fin     = m_busy && wr_ack_i;

    for (int k = 0; k < 9; k++) old_shadow[k] = m_shadow[k];
    if (write_strobe && p >= 2 && p <= 10) m_shadow[p-2] = out_port;
    if (go) for (int k = 0; k < 9; k++) m_live[k] = old_shadow[k];
    if (snap) for (int k = 0; k < 9; k++) m_snap[k] = rd_vals_i[k*8 +: 8];

    if (stat_rd) begin m_done = 0; m_err = 0; m_snapv = 0; end
    if (go)   begin m_req = 1; m_done = 0; m_busy = 1; end
    if (fin)  begin m_req = 0; m_done = 1; m_busy = 0; end
    if (eset) m_err = 1;
    if (snap) m_snapv = 1;
  endtask

  task automatic tick();
    logic [71:0] exp_wr;
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) exp_wr[k*8 +: 8] = m_live[k];
    chk8("in_port", in_port, m_in);
    chk72("wr_regs_o", wr_regs_o, exp_wr);
    chk8("wr_req_o", {7'b0, wr_req_o}, {7'b0, m_req});
  endtask

  task automatic drive(input bit ws, input bit rs, input logic [7:0] pid, input logic [7:0] d);
    write_strobe = ws;
    read_strobe  = rs;
    port_id      = pid;
    out_port     = d;
  endtask

  initial begin
    logic [7:0] ports [20];
    reset = 1'b1; wr_ack_i = 1'b0; rd_vals_i = '0;
    drive(0, 0, 8'h00, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk8("reset_in_port", in_port, 8'h00);
    chk72("reset_wr_regs", wr_regs_o, 72'h0);
    chk8("reset_req", {7'b0, wr_req_o}, 8'h00);

    // 1: shadow writes do not reach live outputs
    drive(1, 0, 8'h02, 8'h24); tick();
    drive(1, 0, 8'h07, 8'h59); tick();
    drive(0, 0, 8'h02, 8'h00); tick();
    chk8("t1_readback", in_port, 8'h24);
    chk72("t1_no_commit", wr_regs_o, 72'h0);

    // 2: commit and handshake
    drive(1, 0, 8'h01, 8'h09); tick();
    chk8("t2_live0", wr_regs_o[0 +: 8], 8'h24);
    chk8("t2_live5", wr_regs_o[40 +: 8], 8'h59);
    chk8("t2_req", {7'b0, wr_req_o}, 8'h01);
    drive(0, 0, 8'h0C, 8'h00); tick();
    chk8("t2_stat_busy", in_port, 8'h01);
    tick();
    wr_ack_i = 1'b1; tick();
    chk8("t2_req_drop", {7'b0, wr_req_o}, 8'h00);
    wr_ack_i = 1'b0;
    drive(0, 1, 8'h0C, 8'h00); tick();
    chk8("t2_stat_done", in_port, 8'h02);
    tick();
    chk8("t2_stat_clr", in_port, 8'h00);

    // 3: commit during handshake flags err, live stays put
    drive(1, 0, 8'h01, 8'h09); tick();
    drive(1, 0, 8'h02, 8'h11); tick();
    drive(1, 0, 8'h01, 8'h09); tick();
    drive(0, 0, 8'h0C, 8'h00); tick();
    chk8("t3_stat_err", in_port, 8'h05);
    chk8("t3_live_kept", wr_regs_o[0 +: 8], 8'h24);
    wr_ack_i = 1'b1; tick();
    wr_ack_i = 1'b0;
    drive(0, 1, 8'h0C, 8'h00); tick();
    chk8("t3_stat_after", in_port, 8'h06);

    // 4: snapshot is coherent
    drive(0, 0, 8'h00, 8'h00);
    rd_vals_i[7:0] = 8'h16;
    drive(1, 0, 8'h01, 8'h0A); tick();
    rd_vals_i[7:0] = 8'h17;
    drive(0, 0, 8'h0D, 8'h00); tick();
    chk8("t4_snap0", in_port, 8'h16);
    drive(0, 1, 8'h0C, 8'h00); tick();
    chk8("t4_stat_snapv", in_port, 8'h08);

    // 5: set beats clear-on-read
    drive(1, 0, 8'h01, 8'h09); tick();
    drive(0, 1, 8'h0C, 8'h00); wr_ack_i = 1'b1; tick();
    chk8("t5_stat_ack", in_port, 8'h11);
    wr_ack_i = 1'b0;
    drive(0, 0, 8'h0C, 8'h00); tick();
    chk8("t5_done_kept", in_port, 8'h02);

    // 6: reset mid-handshake
    drive(1, 0, 8'h01, 8'h09); tick();
    drive(0, 0, 8'h0C, 8'h00);
    reset = 1'b1; tick();
    chk8("t6_req", {7'b0, wr_req_o}, 8'h00);
    chk72("t6_wr_regs", wr_regs_o, 72'h0);
    reset = 1'b0; tick();
    chk8("t6_stat", in_port, 8'h00);
    drive(0, 0, 8'h3F, 8'h00); tick();
    tick();
    chk8("t6_unmapped", in_port, 8'h00);

    // Randomized traffic over mapped and unmapped ports
    for (int k = 0; k < 20; k++) ports[k] = 8'h00;
    ports[0] = 8'h01; ports[1] = 8'h01; ports[2] = 8'h01; ports[3] = 8'h0C;
    ports[4] = 8'h0C; ports[5] = 8'h3F; ports[6] = 8'h00; ports[7] = 8'h16;
    for (int k = 8; k < 20; k++) ports[k] = 8'(k - 6);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] pid;
      logic [7:0] d;
      pid = ports[$urandom_range(0, 19)];
      d   = 8'($urandom);
      if (pid == 8'h01) d = ($urandom_range(0, 1) == 0) ? 8'h09 : (($urandom_range(0, 2) == 0) ? d : 8'h0A);
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), pid, d);
      wr_ack_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) rd_vals_i = {8'($urandom), 64'({$urandom, $urandom})};
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
